// File: rtl/uart_pkt_rx_pkg.sv
// Shared framing constants and deframer state encoding for the UART packet link.
package uart_pkt_rx_pkg;

  localparam int unsigned PAYLOAD_LEN = 128;
  localparam logic [7:0]  SYNC_BYTE   = 8'h7E;
  localparam int unsigned IDX_W       = $clog2(PAYLOAD_LEN);
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    HOLD
  } state_t;

  // Saturating increment for the frame statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload buffer: one write port, registered read port, PAYLOAD_LEN x 8.
module pkt_buf_ram
  import uart_pkt_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [PAYLOAD_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_pkt_rx.sv
// Receive-side deframer: hunts for sync, buffers a fixed payload, checks the XOR
// checksum and holds a good frame until the consumer acknowledges it.
module uart_pkt_rx
  import uart_pkt_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             pkt_rdy,
  input  logic             pkt_ack,
  output logic             crc_err,
  output logic             to_err,
  output logic             ovr,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       csum;
  logic [GAP_W-1:0] gap;
  logic             buf_we;

  assign buf_we = (state == PAYLOAD) && rx_valid;

  pkt_buf_ram u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (idx),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      idx     <= '0;
      csum    <= '0;
      gap     <= '0;
      pkt_rdy <= 1'b0;
      crc_err <= 1'b0;
      to_err  <= 1'b0;
      ovr     <= 1'b0;
      busy    <= 1'b0;
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      crc_err <= 1'b0;
      to_err  <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= PAYLOAD;
            idx   <= '0;
            csum  <= '0;
            gap   <= '0;
            busy  <= 1'b1;
          end
        end
        PAYLOAD, CHECK: begin
          if (rx_valid) begin
            gap <= '0;
            if (state == PAYLOAD) begin
              csum <= csum ^ rx_data;
              idx  <= idx + IDX_W'(1);
              if (idx == LAST_IDX) state <= CHECK;
            end else if (rx_data == csum) begin
              state   <= HOLD;
              pkt_rdy <= 1'b1;
              busy    <= 1'b0;
              pkt_cnt <= sat_inc(pkt_cnt);
            end else begin
              state   <= HUNT;
              crc_err <= 1'b1;
              busy    <= 1'b0;
              err_cnt <= sat_inc(err_cnt);
            end
          end else if (gap == GAP_LAST) begin
            state   <= HUNT;
            to_err  <= 1'b1;
            busy    <= 1'b0;
            gap     <= '0;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        HOLD: begin
          // An ack releases the buffer and lets a coincident byte start a new hunt.
          if (pkt_ack) begin
            pkt_rdy <= 1'b0;
            ovr     <= 1'b0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state <= PAYLOAD;
              idx   <= '0;
              csum  <= '0;
              gap   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= HUNT;
            end
          end else if (rx_valid) begin
            ovr <= 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Randomized self-checking bench for uart_pkt_rx against a frame-level reference model.
module tb_uart_pkt_rx;

  localparam int unsigned T = 20000;
  localparam int unsigned N = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [6:0]  rd_addr = 7'd0;
  logic [7:0]  rd_data;
  logic        pkt_rdy;
  logic        pkt_ack = 1'b0;
  logic        crc_err;
  logic        to_err;
  logic        ovr;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  logic [7:0] pay [N];

  always #5 clk = ~clk;

  uart_pkt_rx #(.TIMEOUT_CYC(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pkt_rdy  (pkt_rdy),
    .pkt_ack  (pkt_ack),
    .crc_err  (crc_err),
    .to_err   (to_err),
    .ovr      (ovr),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference checksum: XOR of the payload bytes only.
  function automatic logic [7:0] ref_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < int'(N); i++) x ^= pay[i];
    return x;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_body(input logic [7:0] cs, input int maxgap);
    for (int i = 0; i < int'(N); i++) send_byte(pay[i], int'($urandom_range(0, maxgap)));
    send_byte(cs, 0);
  endtask

  task automatic send_frame(input logic [7:0] cs, input int maxgap);
    send_byte(8'h7E, int'($urandom_range(0, maxgap)));
    send_body(cs, maxgap);
  endtask

  task automatic check_result(input bit good, input string tag);
    if (good) begin
      exp_pkt++;
      check({tag, "_rdy"}, 32'(pkt_rdy), 32'd1);
      check({tag, "_crc"}, 32'(crc_err), 32'd0);
    end else begin
      exp_err++;
      check({tag, "_crc"}, 32'(crc_err), 32'd1);
      check({tag, "_rdy"}, 32'(pkt_rdy), 32'd0);
      idle(1);
      check({tag, "_crc_pulse"}, 32'(crc_err), 32'd0);
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic read_check(input int a, input string tag);
    rd_addr = 7'(a);
    idle(1);
    check(tag, 32'(rd_data), 32'(pay[a]));
  endtask

  task automatic ack(input string tag);
    pkt_ack = 1'b1;
    idle(1);
    pkt_ack = 1'b0;
    check({tag, "_ack_rdy"}, 32'(pkt_rdy), 32'd0);
    check({tag, "_ack_ovr"}, 32'(ovr), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy"}, 32'(pkt_rdy), 32'd0);
    check({tag, "_crc"}, 32'(crc_err), 32'd0);
    check({tag, "_to"}, 32'(to_err), 32'd0);
    check({tag, "_ovr"}, 32'(ovr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    bit seen;
    bit good;
    logic [7:0] cs;
    logic [7:0] g;

    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // Directed good frame: payload 0x00..0x7F, checksum 0x00.
    for (int i = 0; i < int'(N); i++) pay[i] = 8'(i);
    check("ref_sum_ramp", 32'(ref_xor()), 32'd0);
    send_frame(8'h00, 0);
    check_result(1'b1, "good");
    read_check(5, "good_rd5");
    ack("good");

    // Same payload with a wrong checksum, then the good frame again.
    send_frame(8'h01, 0);
    check_result(1'b0, "badcs");
    send_frame(ref_xor(), 1);
    check_result(1'b1, "after_bad");
    ack("after_bad");

    // Leading garbage then an all-sync payload.
    send_byte(8'h11, 0);
    send_byte(8'h22, 2);
    for (int i = 0; i < int'(N); i++) pay[i] = 8'h7E;
    send_frame(ref_xor(), 0);
    check_result(1'b1, "allsync");
    read_check(0, "allsync_rd0");
    read_check(127, "allsync_rd127");
    ack("allsync");

    // Inter-byte timeout after 10 payload bytes.
    send_byte(8'h7E, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    idle(int'(T) - 5);
    check("to_early", 32'(to_err), 32'd0);
    check("to_busy_before", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      if (to_err) seen = 1'b1;
    end
    check("to_seen", 32'(seen), 32'd1);
    exp_err++;
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_err_cnt", 32'(err_cnt), 32'(exp_err));
    idle(1);
    check("to_pulse", 32'(to_err), 32'd0);
    for (int i = 0; i < int'(N); i++) pay[i] = 8'($urandom);
    send_frame(ref_xor(), 1);
    check_result(1'b1, "after_to");

    // Overrun while holding: bytes are dropped and the buffer is untouched.
    for (int i = 0; i < 3; i++) send_byte(8'h7E, 1);
    check("ovr_set", 32'(ovr), 32'd1);
    check("ovr_rdy", 32'(pkt_rdy), 32'd1);
    for (int i = 0; i < int'(N); i++) read_check(i, "ovr_buf");
    pkt_ack  = 1'b1;
    rx_data  = 8'h7E;
    rx_valid = 1'b1;
    idle(1);
    pkt_ack  = 1'b0;
    rx_valid = 1'b0;
    check("ackSync_ovr", 32'(ovr), 32'd0);
    check("ackSync_rdy", 32'(pkt_rdy), 32'd0);
    check("ackSync_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'(N); i++) pay[i] = 8'($urandom);
    send_body(ref_xor(), 0);
    check_result(1'b1, "ackSync");
    ack("ackSync");

    // Random frames: random payloads, gaps, garbage and checksum corruption.
    for (int f = 0; f < 20; f++) begin
      for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'h7E) g = 8'h00;
        send_byte(g, int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < int'(N); i++) pay[i] = 8'($urandom);
      good = ($urandom_range(0, 9) < 7);
      cs = ref_xor();
      if (!good) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      send_frame(cs, 2);
      check_result(good, "rand");
      if (good) begin
        for (int r = 0; r < 4; r++) read_check(int'($urandom_range(0, N - 1)), "rand_rd");
        idle(int'($urandom_range(0, 3)));
        ack("rand");
      end
    end

    // Reset in the middle of a payload (60 bytes written).
    send_byte(8'h7E, 0);
    for (int i = 0; i < 60; i++) send_byte(8'($urandom), 0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    idle(2);
    rst = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    idle(1);
    for (int i = 0; i < int'(N); i++) pay[i] = 8'($urandom);
    send_frame(ref_xor(), 1);
    check_result(1'b1, "post_rst");
    read_check(77, "post_rst_rd");
    ack("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
